// File: rtl/mips_pkg.sv
// Shared MIPS datapath encodings: ALU control codes, ALUOp values and R-type funct fields.
package mips_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_OR    = 2'b11
    } aluop_e;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/alu_control_decode.sv
// Combinational ALUOp/funct to 3-bit ALU control decode; flags R-type functs the ALU cannot execute.
module alu_control_decode
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_OR:  alu_control = ALU_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: illegal     = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: operand select, immediate extension,
// ALU control decode, stall/flush handling and a saturating bubble counter.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [15:0]       id_imm16,
    input  logic [4:0]        id_rt_addr,
    input  logic [4:0]        id_rd_addr,
    input  logic [1:0]        id_alu_op,
    input  logic [5:0]        id_funct,
    input  logic              id_alu_src,
    input  logic              id_imm_zext,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_branch,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_input_1,
    output logic [DATA_W-1:0] ex_input_2,
    output logic [2:0]        ex_alu_control,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [4:0]        ex_dest_addr,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_branch,
    output logic              ex_illegal,
    output logic [CNT_W-1:0]  bubble_count
);

    logic [DATA_W-1:0] w_imm_ext;
    logic [DATA_W-1:0] w_op2;
    logic [4:0]        w_dest;
    logic [2:0]        w_alu_ctl;
    logic              w_illegal;
    logic              w_bubble;

    logic              r_valid;
    logic [DATA_W-1:0] r_in1;
    logic [DATA_W-1:0] r_in2;
    logic [2:0]        r_alu_ctl;
    logic [DATA_W-1:0] r_store;
    logic [4:0]        r_dest;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_mem_to_reg;
    logic              r_branch;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_bubble_count;

    alu_control_decode u_alu_ctl (
        .alu_op      (id_alu_op),
        .funct       (id_funct),
        .alu_control (w_alu_ctl),
        .illegal     (w_illegal)
    );

    assign w_imm_ext = {{(DATA_W-16){id_imm16[15] & ~id_imm_zext}}, id_imm16};
    assign w_op2     = id_alu_src ? w_imm_ext : id_rt_data;
    assign w_dest    = id_reg_dst ? id_rd_addr : id_rt_addr;
    // Flush overrides stall; an empty decode slot only becomes a bubble when the stage advances.
    assign w_bubble  = flush | (~stall & ~id_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid        <= 1'b0;
            r_in1          <= '0;
            r_in2          <= '0;
            r_alu_ctl      <= ALU_ADD;
            r_store        <= '0;
            r_dest         <= '0;
            r_reg_write    <= 1'b0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_mem_to_reg   <= 1'b0;
            r_branch       <= 1'b0;
            r_illegal      <= 1'b0;
            r_bubble_count <= '0;
        end else if (w_bubble) begin
            r_valid        <= 1'b0;
            r_in1          <= '0;
            r_in2          <= '0;
            r_alu_ctl      <= ALU_ADD;
            r_store        <= '0;
            r_dest         <= '0;
            r_reg_write    <= 1'b0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_mem_to_reg   <= 1'b0;
            r_branch       <= 1'b0;
            r_illegal      <= 1'b0;
            if (r_bubble_count != {CNT_W{1'b1}})
                r_bubble_count <= r_bubble_count + CNT_W'(1);
        end else if (!stall) begin
            // Illegal functs still occupy the slot but must not change architectural state.
            r_valid        <= 1'b1;
            r_in1          <= id_rs_data;
            r_in2          <= w_op2;
            r_alu_ctl      <= w_alu_ctl;
            r_store        <= id_rt_data;
            r_dest         <= w_dest;
            r_reg_write    <= id_reg_write & ~w_illegal;
            r_mem_read     <= id_mem_read;
            r_mem_write    <= id_mem_write & ~w_illegal;
            r_mem_to_reg   <= id_mem_to_reg;
            r_branch       <= id_branch & ~w_illegal;
            r_illegal      <= w_illegal;
        end
    end

    assign ex_valid       = r_valid;
    assign ex_input_1     = r_in1;
    assign ex_input_2     = r_in2;
    assign ex_alu_control = r_alu_ctl;
    assign ex_store_data  = r_store;
    assign ex_dest_addr   = r_dest;
    assign ex_reg_write   = r_reg_write;
    assign ex_mem_read    = r_mem_read;
    assign ex_mem_write   = r_mem_write;
    assign ex_mem_to_reg  = r_mem_to_reg;
    assign ex_branch      = r_branch;
    assign ex_illegal     = r_illegal;
    assign bubble_count   = r_bubble_count;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage directly upstream of the ALU. It registers decoded operands and control from the decode stage and derives the 3-bit ALU control code from ALUOp/funct. It forms the second operand from either the rt register or the extended immediate, and presents `ex_input_1`, `ex_input_2` and `ex_alu_control` to the ALU one cycle later. It supports pipeline stall (hold) and flush (bubble insertion), flags unsupported R-type functs, and counts inserted bubbles.

## Interface
- `DATA_W`, 32, operand width
- `CNT_W`, 16, bubble counter width

- `clk` in 1: rising-edge clock
- `rst_n` in 1: reset, asynchronous, active-low
- `stall` in 1: hold all stage registers
- `flush` in 1: load a bubble
- `id_valid` in 1: decode slot holds a real instruction
- `id_rs_data` in DATA_W: rs register value
- `id_rt_data` in DATA_W: rt register value
- `id_imm16` in 16: instruction immediate
- `id_rt_addr`, `id_rd_addr` in 5: destination candidates
- `id_alu_op` in 2: 00 add, 01 sub, 10 R-type (use funct), 11 or
- `id_funct` in 6: R-type function field
- `id_alu_src` in 1: 0 selects rt, 1 selects the extended immediate
- `id_imm_zext` in 1: 1 zero-extends, 0 sign-extends
- `id_reg_dst` in 1: 1 selects rd, 0 selects rt
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`, `id_branch` in 1: control
- `ex_valid` out 1: EX slot valid
- `ex_input_1` out DATA_W: ALU operand 1 (rs)
- `ex_input_2` out DATA_W: ALU operand 2
- `ex_alu_control` out 3: 000 add, 001 sub, 010 and, 011 or, 100 slt
- `ex_store_data` out DATA_W: registered rt, for stores
- `ex_dest_addr` out 5: write-back register
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_branch` out 1: registered control
- `ex_illegal` out 1: unsupported funct in the EX slot
- `bubble_count` out CNT_W: saturating count of bubbles loaded

## Operation
- Register update priority per rising edge: reset > flush > stall > load.
- **Reset** (async, `rst_n`=0): every output is 0, including `ex_alu_control`=000 and `bubble_count`=0.
- **Bubble** (flush=1, or load with `id_valid`=0):
  - `ex_valid`, all control outputs and `ex_illegal` go to 0.
  - Data/address outputs go to 0.
  - `alu_control` goes to 000.
- **Stall** (stall=1, flush=0): all registers hold, including `bubble_count`.
- **Load** (`id_valid`=1, stall=0, flush=0): registers capture the decoded inputs.
- ALU control decode:
  - ALUOp 00 gives 000; 01 gives 001; 11 gives 011.
  - ALUOp 10 decodes funct: 100000 gives 000, 100010 gives 001, 100100 gives 010, 100101 gives 011, 101010 gives 100.
  - Any other funct with ALUOp 10 gives 000 and sets `ex_illegal`=1. It also forces `ex_reg_write`, `ex_mem_write` and `ex_branch` to 0, while `ex_valid` stays 1.
- Immediate extension: `{16{imm[15]}}` when `id_imm_zext`=0, otherwise `{16'b0}`; the result is DATA_W wide.
- `ex_input_2` = `id_alu_src` ? extended immediate : `id_rt_data`. `ex_store_data` is always `id_rt_data`.
- `ex_dest_addr` = `id_reg_dst` ? rd : rt.
- `bubble_count` increments on every non-stalled edge that loads a bubble, whether from flush or `id_valid`=0. A flush during a stall also counts. The counter saturates at all-ones and does not wrap.

## Timing
- Latency is one cycle from the ID inputs to the EX outputs. All outputs are registered, with no combinational path from input to output.
- Stall and flush take effect at the same edge they are sampled high.
- Flush and stall together: flush wins, a bubble is loaded and counted.
- Reset deasserting mid-stream: the first edge after release performs a normal load. The outputs are bubbles until then.
- Stall held for N cycles: outputs are constant for N cycles, then the pending ID inputs load on the first edge with stall=0.

## Structure
- Shared package `mips_pkg` holds:
  - ALU control codes `ALU_ADD`/`SUB`/`AND`/`OR`/`SLT`.
  - ALUOp encodings.
  - Funct constants `FN_ADD`, `FN_SUB`, `FN_AND`, `FN_OR`, `FN_SLT`.
- Sub-module `alu_control_decode` is purely combinational, mapping `alu_op`, `funct` to `alu_control`, `illegal`. The ALU-side team reuses it.
- The top level contains the extension/mux logic, the stage registers and the counter.

## Test plan
- **Reset:** assert `rst_n`=0 mid-run → all outputs 0 asynchronously, before the next edge.
- **R-type sub:** ALUOp=10, funct=100010, rs=7, rt=3, `reg_dst`=1, rd=9 → next cycle `alu_control`=001, in1=7, in2=3, dest=9, `valid`=1.
- **Immediate extension:**
  - addi, imm=0xFFFC, zext=0, `alu_src`=1 → in2=0xFFFFFFFC, control 000.
  - ori, imm=0x8001, zext=1 → in2=0x00008001, control 011.
- **Illegal funct:** funct=000000 with ALUOp=10 and `reg_write`=1 → `ex_illegal`=1, `ex_reg_write`=0, `ex_valid`=1.
- **Stall 3 cycles, then flush+stall together:**
  - Stall for 3 cycles → outputs hold for 3 cycles.
  - Flush and stall together → bubble loaded, `bubble_count` increments by 1.
- **Counter saturation:** with `CNT_W`=4, apply 20 consecutive flushes → `bubble_count` reaches 15 and stays at 15.
